// File: rtl/uart_frame_receiver_if.sv
// -----------------------------------------------------------------------------
// uart_frame_receiver_if
//   Groups the serial line, the receive-FIFO read port and the error-flag
//   signals of uart_frame_receiver into one bundle.
//
//   Signals
//     rx          serial line into the receiver, idle high
//     rd_en       consumer request to pop the FIFO head byte
//     rd_data     FIFO head byte, 8'h00 when empty
//     rd_valid    FIFO holds at least one byte
//     fifo_count  number of bytes held
//     parity_err  sticky: a frame was dropped for bad parity
//     frame_err   sticky: a frame was dropped for a low stop bit
//     overrun     sticky: a good frame was dropped because the FIFO was full
//     err_clear   clears the three sticky flags
//
//   Modports
//     master  the receiver itself (drives the read data and the flags)
//     slave   the line driver / byte consumer on the far side
// -----------------------------------------------------------------------------
interface uart_frame_receiver_if #(
    parameter int CNT_W = 5
);
    logic             rx;
    logic             rd_en;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic [CNT_W-1:0] fifo_count;
    logic             parity_err;
    logic             frame_err;
    logic             overrun;
    logic             err_clear;

    modport master (
        input  rx, rd_en, err_clear,
        output rd_data, rd_valid, fifo_count, parity_err, frame_err, overrun
    );

    modport slave (
        output rx, rd_en, err_clear,
        input  rd_data, rd_valid, fifo_count, parity_err, frame_err, overrun
    );
endinterface

// File: rtl/uart_frame_receiver.sv
// -----------------------------------------------------------------------------
// uart_frame_receiver
//   Far-end receiver for a UART tx line. A frame is a start bit (0), 8 data
//   bits LSB first, an even parity bit and at least one stop bit (1). Good
//   bytes are queued in a show-ahead FIFO; bad frames are dropped and flagged
//   through sticky error bits.
//
//   Ports
//     clock      system clock, rising edge
//     init_flag  asynchronous active-low reset
//     bus        uart_frame_receiver_if.master (serial in, FIFO read port,
//                sticky error flags and their clear)
// -----------------------------------------------------------------------------
module uart_frame_receiver #(
    parameter int CLKS_PER_BIT = 4166,
    parameter int FIFO_DEPTH   = 16,
    parameter int CNT_W        = 5
) (
    input  logic                   clock,
    input  logic                   init_flag,
    uart_frame_receiver_if.master  bus
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [BW-1:0]    CNT_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]    CNT_HALF = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_t;

    // ------------------------------------------------------------------
    // rx synchronizer (both flops reset to the idle line level)
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_s_q;

    // NOTE: sequential state is updated with <= so every flop samples the
    // pre-edge value of its source; blocking here would collapse the two
    // synchronizer stages into one.
    always_ff @(posedge clock or negedge init_flag) begin
        if (!init_flag) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Frame decoder FSM
    // ------------------------------------------------------------------
    state_t        state_q,   state_d;
    logic [BW-1:0] cnt_q,     cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    data_q,    data_d;
    logic          par_ok_q,  par_ok_d;

    logic push;
    logic set_par;
    logic set_frame;

    always_ff @(posedge clock or negedge init_flag) begin
        if (!init_flag) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
            par_ok_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            par_ok_q  <= par_ok_d;
        end
    end

    // NOTE: every signal driven here gets a default before the case, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        par_ok_d  = par_ok_q;
        push      = 1'b0;
        set_par   = 1'b0;
        set_frame = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!rx_s_q) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end

            // Re-check the line at mid start bit; a short low pulse is a
            // glitch and is ignored without raising any flag.
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d   = ST_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Counting restarts at mid start bit, so each terminal count
            // lands in the middle of the next bit cell.
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d             = '0;
                    data_d[bit_idx_q] = rx_s_q;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    par_ok_d = (rx_s_q == ^data_q);
                    state_d  = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Frame error outranks parity error: only one flag per frame.
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        set_frame = 1'b1;
                        state_d   = ST_BREAK;
                    end else if (!par_ok_q) begin
                        set_par = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // A line held low after a bad stop bit is not a new start bit.
            ST_BREAK: begin
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Show-ahead receive FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic empty;
    logic full;
    logic pop;
    logic push_ok;
    logic overrun_set;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);
    assign pop   = bus.rd_en && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is
    // still accepted then.
    assign push_ok     = push && (!full || pop);
    assign overrun_set = push && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge init_flag) begin
        if (!init_flag) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; an entry is only visible once
    // count covers it, and rd_data is forced to zero while empty.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= data_q;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags (a new event wins over err_clear)
    // ------------------------------------------------------------------
    logic parity_err_q, parity_err_d;
    logic frame_err_q,  frame_err_d;
    logic overrun_q,    overrun_d;

    assign parity_err_d = set_par     | (parity_err_q & ~bus.err_clear);
    assign frame_err_d  = set_frame   | (frame_err_q  & ~bus.err_clear);
    assign overrun_d    = overrun_set | (overrun_q    & ~bus.err_clear);

    always_ff @(posedge clock or negedge init_flag) begin
        if (!init_flag) begin
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.rd_data    = empty ? 8'h00 : mem[rd_ptr_q];
    assign bus.rd_valid   = !empty;
    assign bus.fifo_count = count_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_frame_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_receiver
//   Drives whole UART frames (directed cases plus a randomized run) into
//   uart_frame_receiver and compares FIFO contents and sticky flags against a
//   frame-level reference model: a byte queue and three flag bits.
// -----------------------------------------------------------------------------
module tb_uart_frame_receiver;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic clock     = 1'b0;
    logic init_flag = 1'b0;

    uart_frame_receiver_if #(.CNT_W(CW)) bus ();

    uart_frame_receiver #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .CNT_W        (CW)
    ) dut (
        .clock     (clock),
        .init_flag (init_flag),
        .bus       (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: bytes that should be in the FIFO, and expected flags.
    logic [7:0] m_q[$];
    bit         m_par;
    bit         m_frame;
    bit         m_ovr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] exp_data;
        exp_data = (m_q.size() != 0) ? m_q[0] : 8'h00;
        check({tag, ".count"},  32'(bus.fifo_count), 32'(m_q.size()));
        check({tag, ".valid"},  32'(bus.rd_valid),   32'(m_q.size() != 0));
        check({tag, ".data"},   32'(bus.rd_data),    32'(exp_data));
        check({tag, ".parerr"}, 32'(bus.parity_err), 32'(m_par));
        check({tag, ".frmerr"}, 32'(bus.frame_err),  32'(m_frame));
        check({tag, ".ovr"},    32'(bus.overrun),    32'(m_ovr));
    endtask

    task automatic hold_rx(input logic v, input int clks);
        bus.rx = v;
        repeat (clks) @(negedge clock);
    endtask

    // Sends one frame; hold is the extra low time after a bad stop bit and
    // stop_len the number of stop-bit periods when the stop bit is good.
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop_bit,
                              input int hold, input int stop_len);
        hold_rx(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold_rx(d[i], CPB);
        hold_rx((^d) ^ bad_par, CPB);
        hold_rx(stop_bit, CPB);
        if (!stop_bit) begin
            hold_rx(1'b0, hold);
            hold_rx(1'b1, CPB);
        end else begin
            hold_rx(1'b1, (stop_len - 1) * CPB);
        end
        if (!stop_bit)                  m_frame = 1'b1;
        else if (bad_par)               m_par   = 1'b1;
        else if (m_q.size() == DEPTH)   m_ovr   = 1'b1;
        else                            m_q.push_back(d);
    endtask

    task automatic pop_one(input string tag);
        check({tag, ".pop_valid"}, 32'(bus.rd_valid), 32'(m_q.size() != 0));
        bus.rd_en = 1'b1;
        @(negedge clock);
        bus.rd_en = 1'b0;
        if (m_q.size() != 0) void'(m_q.pop_front());
        check_all(tag);
    endtask

    task automatic clear_errs();
        bus.err_clear = 1'b1;
        @(negedge clock);
        bus.err_clear = 1'b0;
        m_par   = 1'b0;
        m_frame = 1'b0;
        m_ovr   = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx        = 1'b1;
        bus.rd_en     = 1'b0;
        bus.err_clear = 1'b0;
        m_par = 0; m_frame = 0; m_ovr = 0;

        repeat (3) @(negedge clock);
        check_all("reset");
        init_flag = 1'b1;
        hold_rx(1'b1, CPB);

        // Single good frame, then pop.
        send_frame(8'hA5, 1'b0, 1'b1, 0, 1);
        check_all("a5");
        pop_one("a5_pop");

        // Bad parity on 0x01, then clear.
        send_frame(8'h01, 1'b1, 1'b1, 0, 1);
        check_all("par");
        clear_errs();
        check_all("par_clr");

        // Stop bit low, line held low: must wait in break, not start a frame.
        send_frame(8'h3C, 1'b0, 1'b0, 40, 1);
        hold_rx(1'b1, 4 * CPB);
        check_all("frm");
        send_frame(8'h96, 1'b0, 1'b1, 0, 1);
        check_all("frm_next");
        clear_errs();
        pop_one("frm_pop");

        // Short low glitch.
        hold_rx(1'b0, 4);
        hold_rx(1'b1, 2 * CPB);
        check_all("glitch");

        // Five back-to-back frames into a 4-deep FIFO.
        for (int i = 0; i < 5; i++) begin
            send_frame(8'(8'h11 + i), 1'b0, 1'b1, 0, 1);
            check_all("b2b");
        end
        for (int i = 0; i < 4; i++) pop_one("b2b_pop");
        clear_errs();

        // Reset in the middle of a frame with a byte queued and a flag set.
        send_frame(8'h42, 1'b0, 1'b1, 0, 1);
        send_frame(8'h55, 1'b1, 1'b1, 0, 1);
        check_all("pre_rst");
        hold_rx(1'b0, CPB);
        hold_rx(1'b1, 2 * CPB);
        hold_rx(1'b0, CPB / 2);
        init_flag = 1'b0;
        m_q.delete();
        m_par = 0; m_frame = 0; m_ovr = 0;
        hold_rx(1'b1, 3);
        check_all("in_rst");
        init_flag = 1'b1;
        hold_rx(1'b1, CPB);
        check_all("post_rst");
        send_frame(8'h7E, 1'b0, 1'b1, 0, 1);
        check_all("7e");
        pop_one("7e_pop");

        // Randomized frames, pops and clears.
        for (int n = 0; n < 30; n++) begin
            logic [7:0] d;
            int         kind;
            d    = 8'($urandom);
            kind = $urandom_range(0, 9);
            hold_rx(1'b1, $urandom_range(0, 5));
            if (kind == 0)      send_frame(d, 1'b1, 1'b1, 0, $urandom_range(1, 2));
            else if (kind == 1) send_frame(d, 1'b0, 1'b0, $urandom_range(0, 40), 1);
            else                send_frame(d, 1'b0, 1'b1, 0, $urandom_range(1, 2));
            check_all("rnd");
            if ($urandom_range(0, 2) == 0 && m_q.size() != 0) begin
                int k;
                k = $urandom_range(1, m_q.size());
                for (int j = 0; j < k; j++) pop_one("rnd_pop");
            end
            if ($urandom_range(0, 4) == 0) begin
                clear_errs();
                check_all("rnd_clr");
            end
        end
        while (m_q.size() != 0) pop_one("drain");
        pop_one("empty_pop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
